// File: rtl/tone_pkg.sv
// Shared tone constants for the music path: half-period table for C..B at
// 100 MHz, rest threshold and the tone FSM state type.
package tone_pkg;

  localparam int unsigned REF_CLK_HZ    = 100_000_000;
  localparam int          NOTE_REST_MIN = 12;

  localparam logic [19:0] TONE_HP [12] = '{
    20'd764409, 20'd721501, 20'd681013, 20'd642797, 20'd606722, 20'd572672,
    20'd540534, 20'd510202, 20'd481568, 20'd454545, 20'd429037, 20'd404957
  };

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Rescale a reference half period to another system clock, rounding to nearest.
  function automatic longint unsigned scale_hp(longint unsigned clk_hz, logic [3:0] n);
    return (64'(TONE_HP[n]) * clk_hz + 64'(REF_CLK_HZ / 2)) / 64'(REF_CLK_HZ);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV down-counter producing a one-cycle tick on wrap; clr
// restarts a full tick period. Shared with the alarm timebase.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(TICK_DIV - 1);
    end else if (en) begin
      if (cnt == '0) cnt <= CW'(TICK_DIV - 1);
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Plays one note as a square wave on the speaker pin, followed by a silent
// articulation gap and a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for a note from the sequencer (note_ready high)
//   PLAY  | tone running for duration ticks (held low for rests)
//   GAP   | silent articulation gap of GAP_TICKS ticks, done on last cycle
module note_tone_gen
  import tone_pkg::*;
#(
  parameter longint unsigned CLK_HZ    = 100_000_000,
  parameter int              TICK_DIV  = 100_000,
  parameter int              GAP_TICKS = 10,
  parameter int              HP_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [2:0] octave,
  input  logic [3:0] note,
  input  logic [7:0] duration,
  input  logic       mute,
  input  logic       abort,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [HP_W-1:0] hp_tab [12];

  for (genvar i = 0; i < 12; i++) begin : g_tab
    assign hp_tab[i] = HP_W'(scale_hp(CLK_HZ, 4'(i)));
  end

  state_t          state;
  logic [HP_W-1:0] hp_q, hp_cnt;
  logic [7:0]      dur_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            rest_q, tone;

  logic            rest_new;
  logic [3:0]      idx;
  logic [HP_W-1:0] hp_shift, hp_new;
  logic            accept, play_end, tick, presc_clr;

  assign rest_new = note >= 4'(NOTE_REST_MIN);
  assign idx      = rest_new ? 4'd0 : note;
  assign hp_shift = hp_tab[idx] >> octave;
  // Keep the reload value at 2 or more so hp_cnt==1 is always reachable.
  assign hp_new   = (hp_shift < HP_W'(2)) ? HP_W'(2) : hp_shift;

  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = note_valid && note_ready && !abort;
  assign play_end   = (state == PLAY) && tick && (dur_cnt == 8'd1);
  assign done       = (state == GAP) && !abort &&
                      ((gap_cnt == '0) || (tick && (gap_cnt == GW'(1))));
  assign speaker    = tone && !mute;
  assign presc_clr  = accept || (play_end && !abort);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hp_q    <= '0;
      hp_cnt  <= '0;
      dur_cnt <= '0;
      gap_cnt <= '0;
      rest_q  <= 1'b0;
      tone    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hp_q    <= hp_new;
            hp_cnt  <= hp_new;
            rest_q  <= rest_new;
            dur_cnt <= duration;
            gap_cnt <= GW'(GAP_TICKS);
            tone    <= 1'b0;
            state   <= (duration == 8'd0) ? GAP : PLAY;
          end
        end
        PLAY: begin
          if (abort) begin
            tone  <= 1'b0;
            state <= IDLE;
          end else if (play_end) begin
            tone    <= 1'b0;
            dur_cnt <= 8'd0;
            gap_cnt <= GW'(GAP_TICKS);
            state   <= GAP;
          end else begin
            if (tick) dur_cnt <= dur_cnt - 8'd1;
            if (hp_cnt == HP_W'(1)) begin
              hp_cnt <= hp_q;
              tone   <= !tone && !rest_q;
            end else begin
              hp_cnt <= hp_cnt - 1'b1;
            end
          end
        end
        GAP: begin
          tone <= 1'b0;
          if (abort || done) state <= IDLE;
          else if (tick)     gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          tone  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: per-cycle comparison against a timeline model
// (outputs as functions of cycles since accept), plus literal spot checks.
module tb_note_tone_gen;

  localparam int TD = 100;
  localparam int GT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [2:0] octave = '0;
  logic [3:0] note = '0;
  logic [7:0] duration = '0;
  logic       mute = 1'b0;
  logic       abort = 1'b0;
  logic       speaker, busy, done;

  note_tone_gen #(
    .CLK_HZ(100_000_000), .TICK_DIV(TD), .GAP_TICKS(GT), .HP_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .octave(octave), .note(note), .duration(duration), .mute(mute),
    .abort(abort), .speaker(speaker), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int base_hp [12] = '{764409, 721501, 681013, 642797, 606722, 572672,
                       540534, 510202, 481568, 454545, 429037, 404957};

  function automatic int model_hp(int oct, int n);
    int h;
    h = base_hp[n] >>> oct;
    if (h < 2) h = 2;
    return h;
  endfunction

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // model state: note timeline relative to the accept edge
  bit m_active = 0, m_rest = 0;
  int m_j, m_end, m_play, m_hp;
  int cyc = 0, acc_cyc = 0, n_accepts = 0;
  int first_rise = -1, done_cyc = -1, done_cnt = 0, busy_cnt = 0, rise_cnt = 0;
  logic prev_spk = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit e_tone;
    if (!rst_n) begin
      m_active = 0;
    end else begin
      cyc++;
      if (m_active) begin
        if (abort) m_active = 0;
        else begin
          m_j++;
          if (m_j == m_end) m_active = 0;
        end
      end else if (note_valid && !abort) begin
        m_active = 1;
        m_j      = 0;
        m_play   = int'(duration) * TD;
        m_end    = m_play + GT * TD;
        m_hp     = (note >= 12) ? 2 : model_hp(int'(octave), int'(note));
        m_rest   = (note >= 12);
        acc_cyc  = cyc;
        n_accepts++;
      end
    end
    #1;
    e_tone = m_active && !m_rest && (m_j < m_play) && (((m_j / m_hp) % 2) == 1);
    chk("busy",       busy,       m_active);
    chk("note_ready", note_ready, !m_active);
    chk("speaker",    speaker,    e_tone && !mute);
    chk("done",       done,       m_active && (m_j == m_end - 1) && !abort);
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (speaker && !prev_spk) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = cyc;
    end
    prev_spk = speaker;
  end

  task automatic wait_idle(int budget);
    int b = budget;
    while (!note_ready && b > 0) begin @(negedge clk); b--; end
    if (b == 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(int oct, int n, int dur);
    @(negedge clk);
    octave = 3'(oct); note = 4'(n); duration = 8'(dur); note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic clear_marks();
    first_rise = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; rise_cnt = 0;
  endtask

  initial begin
    int acc0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // model pins from the table by hand
    chk("model_hp_a_oct2", model_hp(2, 9), 113636);
    chk("model_hp_b_oct7", model_hp(7, 11), 3163);
    chk("model_hp_a_oct7", model_hp(7, 9), 3551);

    // A at octave 7: first rise hp cycles after accept
    clear_marks();
    send(7, 9, 40);
    wait_idle(5000);
    chk("a7_first_rise", first_rise - acc_cyc, 3551);
    chk("a7_done_time",  done_cyc - acc_cyc, 40 * TD + GT * TD - 1);
    chk("a7_done_count", done_cnt, 1);
    chk("a7_rises",      rise_cnt, 1);

    // rest note
    clear_marks();
    send(0, 12, 3);
    wait_idle(1000);
    chk("rest_busy_cycles", busy_cnt, 500);
    chk("rest_done_count",  done_cnt, 1);
    chk("rest_rises",       rise_cnt, 0);

    // zero duration: gap only
    clear_marks();
    send(3, 5, 0);
    wait_idle(1000);
    chk("dur0_done_time", done_cyc - acc_cyc, GT * TD - 1);
    chk("dur0_rises",     rise_cnt, 0);

    // abort 7 cycles into PLAY, then re-accept with valid held
    clear_marks();
    acc0 = n_accepts;
    send(7, 0, 20);
    repeat (6) @(negedge clk);
    octave = 3'd6; note = 4'd4; duration = 8'd2;
    abort = 1'b1; note_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_to_idle", note_ready, 1);
    @(negedge clk);
    note_valid = 1'b0;
    wait_idle(2000);
    chk("abort_accepts", n_accepts - acc0, 2);
    chk("abort_done_count", done_cnt, 1);

    // mute toggling during PLAY, note_valid held during PLAY
    clear_marks();
    acc0 = n_accepts;
    send(7, 2, 70);
    for (int i = 0; i < 68; i++) begin
      if (i == 3) begin octave = 3'd7; note = 4'd7; duration = 8'd1; note_valid = 1'b1; end
      mute = ((i % 3) == 1);
      repeat (100) @(negedge clk);
    end
    mute = 1'b0;
    wait_idle(2000);
    @(negedge clk);
    note_valid = 1'b0;
    chk("mute_accepts_during_play", n_accepts - acc0, 2);
    wait_idle(2000);
    chk("mute_done_count", done_cnt, 2);

    // randomized notes with sparse mute/abort activity
    for (int k = 0; k < 6; k++) begin
      send($urandom_range(7, 0), $urandom_range(15, 0), $urandom_range(40, 0));
      for (int c = 0; c < 6000 && !note_ready; c++) begin
        if ($urandom_range(99, 0) < 2) mute = ~mute;
        abort = ($urandom_range(2999, 0) == 0);
        @(negedge clk);
      end
      abort = 1'b0;
      mute = 1'b0;
      wait_idle(10);
    end

    // asynchronous reset mid-PLAY while the speaker is high
    send(7, 9, 50);
    repeat (3998) @(negedge clk);
    chk("pre_reset_speaker", speaker, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2;
    chk("reset_speaker", speaker, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", note_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
